// File: rtl/core_test_sequencer.sv
// Run controller for the RISC-V core instruction tests. It holds the core in reset, starts it,
// lets it run for a fixed cycle count, then scans the register file against an expected table.
module core_test_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REGS       = 32,
  parameter int REG_INDEX_BITS = 5,
  parameter int RESET_CYCLES   = 5,
  parameter int RUN_BITS       = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      go,
  input  logic [19:0]               program_base,
  input  logic [RUN_BITS-1:0]       run_cycles,
  output logic                      core_reset,
  output logic                      core_start,
  output logic [19:0]               core_prog_address,
  output logic [REG_INDEX_BITS-1:0] cmp_index,
  input  logic [DATA_WIDTH-1:0]     rf_read_data,
  input  logic [DATA_WIDTH-1:0]     exp_read_data,
  output logic                      busy,
  output logic                      done,
  output logic                      passed,
  output logic [5:0]                mismatch_count,
  output logic [REG_INDEX_BITS-1:0] first_fail_index,
  output logic                      first_fail_valid
);

  typedef enum logic [2:0] {IDLE, RESET_HOLD, START, RUN, COMPARE, REPORT} state_t;

  // One counter is shared by the reset-hold, run and compare phases.
  localparam int CNT_W = (RUN_BITS > 7) ? RUN_BITS : 7;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [19:0]         base_q;
  logic [RUN_BITS-1:0] run_len;
  logic                mismatch;
  logic [5:0]          mismatch_next;

  // Read data lags cmp_index by one cycle, so the first COMPARE cycle has nothing to check.
  always_comb begin
    mismatch      = (state == COMPARE) && (cnt != '0) && (rf_read_data != exp_read_data);
    mismatch_next = mismatch_count;
    if (mismatch && (mismatch_count != 6'd63)) mismatch_next = mismatch_count + 6'd1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples the
  // pre-edge values and the order of statements inside this block does not matter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= '0;
      base_q            <= '0;
      run_len           <= '0;
      core_reset        <= 1'b1;
      core_start        <= 1'b0;
      core_prog_address <= '0;
      cmp_index         <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      passed            <= 1'b0;
      mismatch_count    <= '0;
      first_fail_index  <= '0;
      first_fail_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            state            <= RESET_HOLD;
            busy             <= 1'b1;
            core_reset       <= 1'b1;
            base_q           <= program_base;
            run_len          <= (run_cycles == '0) ? RUN_BITS'(1) : run_cycles;
            cnt              <= CNT_W'(RESET_CYCLES - 1);
            passed           <= 1'b0;
            mismatch_count   <= '0;
            first_fail_index <= '0;
            first_fail_valid <= 1'b0;
          end
        end
        RESET_HOLD: begin
          if (cnt == '0) begin
            state             <= START;
            core_reset        <= 1'b0;
            core_start        <= 1'b1;
            core_prog_address <= base_q;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        START: begin
          state      <= RUN;
          core_start <= 1'b0;
          cnt        <= CNT_W'(run_len) - CNT_W'(1);
        end
        RUN: begin
          if (cnt == '0) begin
            state     <= COMPARE;
            cmp_index <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        COMPARE: begin
          mismatch_count <= mismatch_next;
          if (mismatch && !first_fail_valid) begin
            first_fail_index <= REG_INDEX_BITS'(cnt - CNT_W'(1));
            first_fail_valid <= 1'b1;
          end
          if (cnt == CNT_W'(NUM_REGS)) begin
            state     <= REPORT;
            done      <= 1'b1;
            passed    <= (mismatch_next == '0);
            cmp_index <= '0;
          end else begin
            cnt       <= cnt + CNT_W'(1);
            cmp_index <= (cnt == CNT_W'(NUM_REGS - 1)) ? '0 : REG_INDEX_BITS'(cnt + CNT_W'(1));
          end
        end
        REPORT: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/core_test_sequencer.md
Name: core_test_sequencer

Overview:
Hardware run controller for the RISC_V_Core instruction-test flow.
- Holds the core in reset, then pulses start with a program base address.
- Lets the core run for a programmed number of cycles.
- Scans the core register file against an expected-value table, one index per cycle.
- Reports pass/fail, mismatch count and first failing register.
- Sits beside the core in self-checking builds. Replaces time-based waits and the hierarchical register-file compare.

Parameters:
DATA_WIDTH, 32, register and expected-value width
NUM_REGS, 32, registers scanned (max 63)
REG_INDEX_BITS, 5, width of compare index
RESET_CYCLES, 5, cycles core_reset is held after go (min 1)
RUN_BITS, 16, width of run_cycles

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high block reset
go  in  1  start a test run; sampled only in IDLE
program_base  in  20  start PC handed to core
run_cycles  in  RUN_BITS  cycles to let core execute; 0 treated as 1
core_reset  out  1  drives core reset
core_start  out  1  drives core start
core_prog_address  out  20  drives core prog_address
cmp_index  out  REG_INDEX_BITS  read index to register file and expected table
rf_read_data  in  DATA_WIDTH  register file data, valid 1 cycle after cmp_index
exp_read_data  in  DATA_WIDTH  expected data, valid 1 cycle after cmp_index
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse in REPORT
passed  out  1  1 when mismatch_count==0; valid from done, held
mismatch_count  out  6  number of mismatching registers
first_fail_index  out  REG_INDEX_BITS  lowest mismatching index
first_fail_valid  out  1  at least one mismatch

Behaviour:
- Reset values: state=IDLE; core_reset=1; core_start=0; core_prog_address=0; cmp_index=0; busy=0; done=0; passed=0; mismatch_count=0; first_fail_index=0; first_fail_valid=0.
- Reset asserted mid-operation: immediate return to IDLE. Outputs go to reset values, and no done pulse is produced for the aborted run.
- State machine: IDLE -> RESET_HOLD -> START -> RUN -> COMPARE -> REPORT -> IDLE.
- IDLE, go=1 at edge E:
  - Latch program_base and run_cycles (0 becomes 1).
  - Clear mismatch_count, first_fail_*, passed.
  - Enter RESET_HOLD.
- IDLE, go=0: core_reset keeps its last value (1 after block reset, 0 after a completed run). Result outputs hold.
- RESET_HOLD: core_reset=1 for exactly RESET_CYCLES cycles.
- START: one cycle with core_reset=0, core_start=1, core_prog_address=latched base.
- RUN: core_start=0, core_reset=0, for exactly the latched run count. A down-counter is used; no core feedback.
- COMPARE: NUM_REGS+1 cycles.
  - Cycle k (0..NUM_REGS-1) drives cmp_index=k.
  - Cycle k+1 compares rf_read_data against exp_read_data for index k. Register 0 is compared too.
  - On mismatch, mismatch_count increments (saturates at 63).
  - On the first mismatch, first_fail_index=k and first_fail_valid=1.
  - cmp_index returns to 0 after the scan.
- REPORT: done=1 for one cycle, passed=(mismatch_count==0). Then IDLE.
- Latency: with go sampled at edge 0, R=RESET_CYCLES and N=run count:
  - RESET_HOLD occupies cycles 1..R.
  - START is cycle R+1.
  - RUN is cycles R+2..R+N+1.
  - COMPARE is cycles R+N+2..R+N+NUM_REGS+2.
  - done is at cycle R+N+NUM_REGS+3.
- go while busy (including the REPORT cycle) is ignored, not queued.
- Results stay stable from done until the next accepted go.
- The core is left running (core_reset=0) after REPORT. Test programs end in a self-loop, so the register file stays stable.

Test Plan:
- Defaults, program_base=0x00000, run_cycles=50, expected table equal to register file (e.g. x11=0x00001000, x12=0x80000000, x15=0xffffffff, x16=0x00001400) -> core_reset high cycles 1-5; core_start high only cycle 6 with prog_address 0x00000; done at cycle 90; passed=1, mismatch_count=0, first_fail_valid=0.
- Same run, expected table wrong at x12 (0x80000001) and x17 (0x00000000 vs 0xfffff000) -> done cycle 90; passed=0, mismatch_count=2, first_fail_index=12, first_fail_valid=1.
- run_cycles=0, program_base=0x00040 -> run phase lasts 1 cycle; done at cycle 41; core_prog_address=0x00040 during START.
- go pulsed during RUN and again in the REPORT cycle -> both ignored; exactly one done; next go in IDLE is accepted and clears the previous results.
- reset asserted during COMPARE (cycle 60) -> same-cycle core_reset=1, busy=0, mismatch_count=0, no done pulse; a new go afterwards completes normally.
- All 32 entries mismatching -> mismatch_count=32, first_fail_index=0, passed=0.
